// File: rtl/dffe_arb_pkg.sv
// Shared types and helpers for the round-robin arbitrated shared register.
package dffe_arb_pkg;

  localparam int unsigned DefNReq  = 4;
  localparam int unsigned DefWidth = 8;
  localparam int unsigned MaxReq   = 8;
  localparam int unsigned MaxIdW   = 3;

  typedef enum logic [0:0] {
    StArb,
    StLocked
  } arb_state_e;

  function automatic logic [MaxReq-1:0] onehot(input logic [MaxIdW-1:0] idx);
    logic [MaxReq-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick #(
  parameter int unsigned NReq = 4,
  parameter int unsigned IdW  = 2
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic            found_o,
  output logic [IdW-1:0]  idx_o
);

  int cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    // Scan highest offset first so the lowest offset from ptr wins last.
    for (int i = NReq - 1; i >= 0; i--) begin
      cand = (int'(ptr_i) + i) % int'(NReq);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IdW'(cand);
      end
    end
  end

endmodule

// File: rtl/dffe_write_arbiter.sv
// Shared enabled register written by N_REQ requesters under round-robin arbitration with lock.
module dffe_write_arbiter
  import dffe_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DefNReq,
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         lock_i,
  input  logic [N_REQ*WIDTH-1:0]   wdata_i,
  input  logic                     clr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [WIDTH-1:0]         q_o,
  output logic                     valid_o,
  output logic [$clog2(N_REQ)-1:0] owner_o
);

  localparam int unsigned IDW = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic             hold_lock;

  rr_pick #(
    .NReq (N_REQ),
    .IdW  (IDW)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .found_o (win_found),
    .idx_o   (win_idx)
  );

  assign hold_lock = (state_q == StLocked) && req_i[owner_q] && lock_i[owner_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    q_d     = q_q;
    valid_d = valid_q;
    gnt_d   = '0;
    if (clr_i) begin
      q_d     = '0;
      valid_d = 1'b0;
      state_d = StArb;
    end else if (hold_lock) begin
      q_d     = wdata_i[owner_q*WIDTH +: WIDTH];
      valid_d = 1'b1;
      gnt_d   = N_REQ'(onehot(MaxIdW'(owner_q)));
    end else if (win_found) begin
      // A lapsed lock falls through to normal arbitration in the same cycle.
      q_d     = wdata_i[win_idx*WIDTH +: WIDTH];
      valid_d = 1'b1;
      owner_d = win_idx;
      gnt_d   = N_REQ'(onehot(MaxIdW'(win_idx)));
      ptr_d   = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + IDW'(1);
      state_d = lock_i[win_idx] ? StLocked : StArb;
    end else begin
      state_d = StArb;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StArb;
      ptr_q   <= '0;
      owner_q <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign q_o     = q_q;
  assign valid_o = valid_q;
  assign owner_o = owner_q;

endmodule

// File: tb/tb_dffe_write_arbiter.sv
// Directed bench for dffe_write_arbiter with hand-computed expectations.
module tb_dffe_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic        clr;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        valid;
  logic [1:0]  owner;

  int n_tests = 0;
  int n_fail  = 0;

  dffe_write_arbiter #(
    .N_REQ (4),
    .WIDTH (8)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .lock_i  (lock),
    .wdata_i (wdata),
    .clr_i   (clr),
    .gnt_o   (gnt),
    .q_o     (q),
    .valid_o (valid),
    .owner_o (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_q,
                             input logic e_valid, input logic [1:0] e_owner);
    check({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
    check({tag, ".q"},     32'(q),     32'(e_q));
    check({tag, ".valid"}, 32'(valid), 32'(e_valid));
    check({tag, ".owner"}, 32'(owner), 32'(e_owner));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    clr   = 1'b0;
    wdata = {8'h33, 8'h22, 8'h11, 8'h00};

    // Reset holds everything at zero even with all requests pending.
    #1;
    check_state("reset0", 4'b0000, 8'h00, 1'b0, 2'd0);
    step();
    step();
    check_state("reset1", 4'b0000, 8'h00, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: grants 0,1,2,3,0 with matching lane data.
    for (int k = 0; k < 5; k++) begin
      logic [1:0] e_idx;
      logic [7:0] e_q;
      e_idx = 2'(k % 4);
      e_q   = 8'h11 * 8'(k % 4);
      step();
      check_state($sformatf("fair%0d", k), 4'b0001 << e_idx, e_q, 1'b1, e_idx);
    end

    // Single requester 2 (ptr is 1 here).
    req   = 4'b0100;
    wdata = {8'h33, 8'hA5, 8'h11, 8'h00};
    step();
    check_state("single", 4'b0100, 8'hA5, 1'b1, 2'd2);
    req = 4'b0000;
    step();
    check_state("single_hold", 4'b0000, 8'hA5, 1'b1, 2'd2);

    // Clear beats a simultaneous request; request served next edge (ptr=3 -> wraps to 1).
    req   = 4'b0010;
    clr   = 1'b1;
    wdata = {8'h33, 8'hA5, 8'h77, 8'h00};
    step();
    check_state("clr", 4'b0000, 8'h00, 1'b0, 2'd2);
    clr = 1'b0;
    step();
    check_state("after_clr", 4'b0010, 8'h77, 1'b1, 2'd1);

    // Lock burst by requester 1; requester 3 waits, then wins when lock drops.
    req   = 4'b0010;
    lock  = 4'b0010;
    wdata = {8'hC3, 8'hA5, 8'h5A, 8'h00};
    step();
    check_state("lock0", 4'b0010, 8'h5A, 1'b1, 2'd1);
    req   = 4'b1010;
    wdata = {8'hC3, 8'hA5, 8'h5B, 8'h00};
    step();
    check_state("lock1", 4'b0010, 8'h5B, 1'b1, 2'd1);
    wdata = {8'hC3, 8'hA5, 8'h5C, 8'h00};
    step();
    check_state("lock2", 4'b0010, 8'h5C, 1'b1, 2'd1);
    req  = 4'b1000;
    lock = 4'b0000;
    step();
    check_state("unlock", 4'b1000, 8'hC3, 1'b1, 2'd3);

    // Re-lock on requester 1 (ptr=0), then asynchronous reset between edges.
    req   = 4'b0010;
    lock  = 4'b0010;
    wdata = {8'hC3, 8'hA5, 8'h5A, 8'h00};
    step();
    check_state("relock", 4'b0010, 8'h5A, 1'b1, 2'd1);
    step();
    check_state("relock_hold", 4'b0010, 8'h5A, 1'b1, 2'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 4'b0000, 8'h00, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    lock  = 4'b0000;
    wdata = {8'h33, 8'h22, 8'h11, 8'h44};
    step();
    check_state("post_rst", 4'b0001, 8'h44, 1'b1, 2'd0);
    step();
    check_state("post_rst2", 4'b0010, 8'h11, 1'b1, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dffe_write_arbiter.md
Name: dffe_write_arbiter

Overview:
Shares one WIDTH-bit enabled register (dffe-style storage with synchronous clear) among N_REQ requesters. A round-robin arbiter picks at most one requester per cycle and drives the register's enable and data. It also supports an optional lock, so one requester can hold the register for a burst. The block sits between requester logic and any consumer of the shared register value q.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, width of the shared register and of each write-data lane
IDW, $clog2(N_REQ), width of the owner index (derived, not overridable)

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester write request, held until granted
lock  in  N_REQ  per-requester lock; meaningful only together with req
wdata  in  N_REQ*WIDTH  write data; lane i is bits [i*WIDTH +: WIDTH]
clr  in  1  synchronous clear of the shared register; highest priority
gnt  out  N_REQ  registered one-hot acknowledge, one-cycle pulse
q  out  WIDTH  shared register contents
valid  out  1  q holds data written since the last reset or clr
owner  out  IDW  index of the last requester written

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - q=0, valid=0, gnt=0, owner=0.
  - ptr=0, so requester 0 has first priority.
  - FSM goes to ARB.
- FSM states: ARB (round-robin) and LOCKED (a single owner is served).
- ARB, clr=0, any req set:
  - Winner w is the first requester with req set, scanning from ptr upward with wrap (ptr, ptr+1, ..., N_REQ-1, 0, ...).
  - At the edge: q<=wdata lane w, valid<=1, owner<=w, gnt<=onehot(w), ptr<=(w+1) mod N_REQ.
  - If lock[w]=1, go to LOCKED; otherwise stay in ARB.
- ARB, no req: no write, gnt<=0, ptr and q unchanged.
- LOCKED with req[owner]=1 and lock[owner]=1:
  - The only requester considered is owner.
  - It writes every cycle: q<=its lane, gnt<=onehot(owner).
  - ptr is not changed; other requests wait.
- LOCKED with req[owner]=0 or lock[owner]=0:
  - Return to ARB and run normal round-robin arbitration in the same cycle, using the current ptr.
  - If owner still has req set but not lock, it competes normally.
- Handshake: write latency is 1 cycle. gnt[i] is high in the cycle after lane i was captured. The requester changes data, or drops req, in that cycle. A req still high in the gnt cycle counts as a new request.
- clr=1 at an edge, in any state:
  - q<=0, valid<=0, gnt<=0, FSM<=ARB.
  - ptr and owner are unchanged; pending requests are served from the next cycle.
  - A simultaneous req is not granted.
- At most one gnt bit is ever set. gnt is never high while clr was high on the preceding edge.
- rst_n asserted mid-burst clears everything immediately, without waiting for a clock edge. After release, arbitration restarts from requester 0.

Decomposition:
- Shared package dffe_arb_pkg:
  - Default constants for N_REQ and WIDTH.
  - State enum {ARB, LOCKED}.
  - Function onehot(idx).
- One sub-module, rr_pick: combinational, inputs req and ptr, outputs found and idx.
  - It is instantiated once in the top.
  - The top holds the FSM, ptr, q, valid, owner and gnt registers.

Test Plan:
- Reset values: hold rst_n=0 with req=4'b1111 -> q=0, valid=0, gnt=0, owner=0. Release rst_n -> the first grant goes to requester 0 (gnt=4'b0001 one cycle later).
- Single requester: req=4'b0100, lane2=8'hA5 for one edge -> next cycle q=8'hA5, valid=1, owner=2, gnt=4'b0100. Drop req -> gnt=0, q holds 8'hA5.
- Fairness: req=4'b1111 held continuously, lanes={8'h33,8'h22,8'h11,8'h00} for lanes 3..0 -> grants in order 0,1,2,3,0. q sequence is 00,11,22,33,00.
- Clear priority: clr=1 and req=4'b0010 on the same edge -> q=0, valid=0, gnt=0. On the following edge requester 1 is written and gnt=4'b0010.
- Lock burst: requester 1 holds req and lock for 3 cycles while requester 3 requests -> three consecutive gnt=4'b0010 pulses. After lock drops, requester 3 is granted on the next edge.
- Reset mid-operation: assert rst_n=0 asynchronously between edges while LOCKED with q=8'h5A -> q=0, valid=0 and gnt=0 without a clock edge. After release the FSM is in ARB with ptr=0.
